param_update_engine: RTL and testbench

Parametrised successor to the single-shot parameter-update unit: a sequential engine that walks a tensor of LEN fixed-point elements in memory and applies either plain SGD (w ← w − lr·g) or momentum SGD (v ← mu·v + g; w ← w − lr·v). Sits between the worker's layer scheduler (go/done) and a shared scratchpad memory port. Configuration is latched at start, and memory stalls are tolerated through a request/grant handshake.

---
 rtl/param_update_pkg.sv | 32 +++
 rtl/fxp_mul_shift_sat.sv | 32 +++
 rtl/param_update_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_param_update_engine.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_update_pkg.sv
// Shared types and limits for the parameter-update engine: FSM state
// encoding, update-mode encoding and the default saturation bounds.
package param_update_pkg;

  localparam int PU_DATA_W = 32;
  localparam int PU_FRAC_W = 16;
  localparam int PU_ADDR_W = 16;
  localparam int PU_LEN_W  = 16;

  localparam logic signed [PU_DATA_W-1:0] SAT_MAX = {1'b0, {(PU_DATA_W-1){1'b1}}};
  localparam logic signed [PU_DATA_W-1:0] SAT_MIN = {1'b1, {(PU_DATA_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RW_REQ  = 4'd1,
    S_RW_WAIT = 4'd2,
    S_RG_REQ  = 4'd3,
    S_RG_WAIT = 4'd4,
    S_RV_REQ  = 4'd5,
    S_RV_WAIT = 4'd6,
    S_EX      = 4'd7,
    S_WV      = 4'd8,
    S_WW      = 4'd9,
    S_DONE    = 4'd10
  } state_e;

  typedef enum logic {
    MODE_SGD = 1'b0,
    MODE_MOM = 1'b1
  } mode_e;

endpackage

// File: rtl/fxp_mul_shift_sat.sv
// Combinational fixed-point step: y = sat(c +/- ((a*b) >>> FRAC_W)).
// The shift floors (rounds toward minus infinity); sat_o flags a clamp.
module fxp_mul_shift_sat #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [DATA_W-1:0] c_i,
  input  logic                     sub_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;
  logic signed [SW-1:0] sum;
  logic        [DATA_W+1:0] sum_top;

  assign prod    = PW'(a_i) * PW'(b_i);
  assign prod_sh = prod >>> FRAC_W;
  assign sum     = sub_i ? (SW'(c_i) - SW'(prod_sh)) : (SW'(c_i) + SW'(prod_sh));

  // In range only when every bit above the result sign matches it.
  assign sum_top = sum[SW-1:DATA_W-1];
  assign sat_o   = !((&sum_top) || !(|sum_top));
  assign y_o     = sat_o ? {sum[SW-1], {(DATA_W-1){~sum[SW-1]}}} : sum[DATA_W-1:0];

endmodule

// File: rtl/param_update_engine.sv
// Sequential SGD / momentum-SGD parameter update over a tensor in memory.
// Build option: define PARAM_UPDATE_MOMENTUM_EN to enable momentum mode;
// without it mode_i is ignored and only plain SGD is performed.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for go, config latched on acceptance
// RW_REQ    | request read of w[i]
// RW_WAIT   | wait for w[i] read data
// RG_REQ    | request read of g[i]
// RG_WAIT   | wait for g[i] read data
// RV_REQ    | request read of v[i] (momentum only)
// RV_WAIT   | wait for v[i] read data (momentum only)
// EX        | compute v' and w', accumulate sticky sat
// WV        | write v'[i] (momentum only)
// WW        | write w'[i], then next element or finish
// DONE      | one-cycle completion pulse
module param_update_engine
  import param_update_pkg::*;
#(
  parameter int DATA_W = PU_DATA_W,
  parameter int FRAC_W = PU_FRAC_W,
  parameter int ADDR_W = PU_ADDR_W,
  parameter int LEN_W  = PU_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic              mode_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] g_base_i,
  input  logic [ADDR_W-1:0] v_base_i,
  input  logic [DATA_W-1:0] lr_i,
  input  logic [DATA_W-1:0] mu_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sat_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e                     state_q, state_d;
  logic        [LEN_W-1:0]    i_q, i_d, len_q, len_d;
  logic        [ADDR_W-1:0]   w_base_q, w_base_d, g_base_q, g_base_d;
  logic signed [DATA_W-1:0]   lr_q, lr_d, w_q, w_d, g_q, g_d, w_new_q, w_new_d;
  logic                       sat_q, sat_d;
  logic signed [DATA_W-1:0]   w_mul_b, w_res;
  logic                       w_sat;

`ifdef PARAM_UPDATE_MOMENTUM_EN
  mode_e                      mode_q, mode_d;
  logic        [ADDR_W-1:0]   v_base_q, v_base_d;
  logic signed [DATA_W-1:0]   mu_q, mu_d, v_q, v_d, v_new_q, v_new_d;
  logic signed [DATA_W-1:0]   v_res;
  logic                       v_sat;

  fxp_mul_shift_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_v_update (
    .a_i   (mu_q),
    .b_i   (v_q),
    .c_i   (g_q),
    .sub_i (1'b0),
    .y_o   (v_res),
    .sat_o (v_sat)
  );

  // Momentum scales the clamped velocity, SGD scales the raw gradient.
  assign w_mul_b = (mode_q == MODE_MOM) ? v_res : g_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode_i, v_base_i, mu_i};
  assign w_mul_b    = g_q;
`endif

  fxp_mul_shift_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_w_update (
    .a_i   (lr_q),
    .b_i   (w_mul_b),
    .c_i   (w_q),
    .sub_i (1'b1),
    .y_o   (w_res),
    .sat_o (w_sat)
  );

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      len_q    <= '0;
      w_base_q <= '0;
      g_base_q <= '0;
      lr_q     <= '0;
      w_q      <= '0;
      g_q      <= '0;
      w_new_q  <= '0;
      sat_q    <= 1'b0;
`ifdef PARAM_UPDATE_MOMENTUM_EN
      mode_q   <= MODE_SGD;
      v_base_q <= '0;
      mu_q     <= '0;
      v_q      <= '0;
      v_new_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      len_q    <= len_d;
      w_base_q <= w_base_d;
      g_base_q <= g_base_d;
      lr_q     <= lr_d;
      w_q      <= w_d;
      g_q      <= g_d;
      w_new_q  <= w_new_d;
      sat_q    <= sat_d;
`ifdef PARAM_UPDATE_MOMENTUM_EN
      mode_q   <= mode_d;
      v_base_q <= v_base_d;
      mu_q     <= mu_d;
      v_q      <= v_d;
      v_new_q  <= v_new_d;
`endif
    end
  end

  // Next-state sequencing and memory-port outputs decoded from state.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    len_d    = len_q;
    w_base_d = w_base_q;
    g_base_d = g_base_q;
    lr_d     = lr_q;
    w_d      = w_q;
    g_d      = g_q;
    w_new_d  = w_new_q;
    sat_d    = sat_q;
`ifdef PARAM_UPDATE_MOMENTUM_EN
    mode_d   = mode_q;
    v_base_d = v_base_q;
    mu_d     = mu_q;
    v_d      = v_q;
    v_new_d  = v_new_q;
`endif
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    sat_o       = sat_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          len_d    = len_i;
          w_base_d = w_base_i;
          g_base_d = g_base_i;
          lr_d     = lr_i;
`ifdef PARAM_UPDATE_MOMENTUM_EN
          mode_d   = mode_e'(mode_i);
          v_base_d = v_base_i;
          mu_d     = mu_i;
`endif
          i_d      = '0;
          sat_d    = 1'b0;
          state_d  = (len_i == '0) ? S_DONE : S_RW_REQ;
        end
      end
      S_RW_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = w_base_q + ADDR_W'(i_q);
        if (mem_gnt_i) state_d = S_RW_WAIT;
      end
      S_RW_WAIT: begin
        if (mem_rvalid_i) begin
          w_d     = mem_rdata_i;
          state_d = S_RG_REQ;
        end
      end
      S_RG_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = g_base_q + ADDR_W'(i_q);
        if (mem_gnt_i) state_d = S_RG_WAIT;
      end
      S_RG_WAIT: begin
        if (mem_rvalid_i) begin
          g_d     = mem_rdata_i;
`ifdef PARAM_UPDATE_MOMENTUM_EN
          state_d = (mode_q == MODE_MOM) ? S_RV_REQ : S_EX;
`else
          state_d = S_EX;
`endif
        end
      end
`ifdef PARAM_UPDATE_MOMENTUM_EN
      S_RV_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = v_base_q + ADDR_W'(i_q);
        if (mem_gnt_i) state_d = S_RV_WAIT;
      end
      S_RV_WAIT: begin
        if (mem_rvalid_i) begin
          v_d     = mem_rdata_i;
          state_d = S_EX;
        end
      end
`endif
      S_EX: begin
        w_new_d = w_res;
`ifdef PARAM_UPDATE_MOMENTUM_EN
        v_new_d = v_res;
        sat_d   = sat_q | w_sat | (v_sat & (mode_q == MODE_MOM));
        state_d = (mode_q == MODE_MOM) ? S_WV : S_WW;
`else
        sat_d   = sat_q | w_sat;
        state_d = S_WW;
`endif
      end
`ifdef PARAM_UPDATE_MOMENTUM_EN
      S_WV: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = v_base_q + ADDR_W'(i_q);
        mem_wdata_o = v_new_q;
        if (mem_gnt_i) state_d = S_WW;
      end
`endif
      S_WW: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_base_q + ADDR_W'(i_q);
        mem_wdata_o = w_new_q;
        if (mem_gnt_i) begin
          if ((i_q + LEN_W'(1)) == len_q) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + LEN_W'(1);
            state_d = S_RW_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_param_update_engine.sv
// Self-checking bench for param_update_engine: a behavioural memory with
// optional write stalls, and a write scoreboard filled from a reference model.
module tb_param_update_engine;
  import param_update_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          go_i, mode_i;
  logic [LW-1:0] len_i;
  logic [AW-1:0] w_base_i, g_base_i, v_base_i;
  logic [DW-1:0] lr_i, mu_i;
  logic          busy_o, done_o, sat_o, mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  bit   [DW-1:0] mem [65536];
  int            checks = 0;
  int            errors = 0;
  int            req_cycles = 0;
  int            stall_req = 0;
  int            stall_cnt = 0;
  bit            rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  bit            exp_sat;
  bit            eff_mom;

  param_update_engine dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .go_i         (go_i),
    .mode_i       (mode_i),
    .len_i        (len_i),
    .w_base_i     (w_base_i),
    .g_base_i     (g_base_i),
    .v_base_i     (v_base_i),
    .lr_i         (lr_i),
    .mu_i         (mu_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sat_o        (sat_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder: decides grant on the falling edge, returns read data
  // one cycle after the grant, pops the scoreboard on every granted write.
  always @(negedge clk_i) begin
    wr_t e;
    mem_rvalid_i = 1'b0;
    if (rd_pend) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem[rd_addr];
      rd_pend      = 1'b0;
    end
    mem_gnt_i = 1'b0;
    if (rst_i) begin
      stall_cnt = 0;
    end else if (mem_req_o === 1'b1) begin
      req_cycles++;
      if (mem_we_o && stall_req > 0 && stall_cnt == 0) begin
        hold_addr = mem_addr_o;
        hold_data = mem_wdata_o;
      end
      if (mem_we_o && stall_req > 0 && stall_cnt > 0) begin
        checks++;
        if (mem_addr_o !== hold_addr || mem_wdata_o !== hold_data) begin
          errors++;
          $display("FAIL stall_hold: addr=%h wdata=%h, required addr=%h wdata=%h",
                   mem_addr_o, mem_wdata_o, hold_addr, hold_data);
        end
      end
      if (mem_we_o && stall_cnt < stall_req) begin
        stall_cnt++;
      end else begin
        if (mem_we_o) begin
          stall_req = 0;
          stall_cnt = 0;
        end
        mem_gnt_i = 1'b1;
        if (mem_we_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_write: got addr=%h data=%h, required no write",
                     mem_addr_o, mem_wdata_o);
          end else begin
            e = exp_q.pop_front();
            if (mem_addr_o !== e.addr || mem_wdata_o !== e.data) begin
              errors++;
              $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                       mem_addr_o, mem_wdata_o, e.addr, e.data);
            end
          end
          mem[mem_addr_o] = mem_wdata_o;
        end else begin
          rd_pend = 1'b1;
          rd_addr = mem_addr_o;
        end
      end
    end
  end

  function automatic longint mulsh(logic [DW-1:0] a, logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p >>> 16;
  endfunction

  function automatic logic [DW-1:0] clamp(longint x, output bit s);
    s = 1'b0;
    if (x > longint'(SAT_MAX)) begin
      s = 1'b1;
      return SAT_MAX;
    end
    if (x < longint'(SAT_MIN)) begin
      s = 1'b1;
      return SAT_MIN;
    end
    return x[DW-1:0];
  endfunction

  task automatic push_expect(bit mom, int len, logic [AW-1:0] wb, logic [AW-1:0] gb,
                             logic [AW-1:0] vb, logic [DW-1:0] lr, logic [DW-1:0] mu);
    logic [AW-1:0] aw, ag, av;
    logic [DW-1:0] vn, wn;
    bit s1, s2;
    exp_sat = 1'b0;
    for (int i = 0; i < len; i++) begin
      aw = wb + AW'(i);
      ag = gb + AW'(i);
      av = vb + AW'(i);
      if (mom) begin
        vn = clamp(mulsh(mu, mem[av]) + longint'($signed(mem[ag])), s1);
        wn = clamp(longint'($signed(mem[aw])) - mulsh(lr, vn), s2);
        exp_q.push_back({av, vn});
        exp_q.push_back({aw, wn});
        exp_sat = exp_sat | s1 | s2;
      end else begin
        wn = clamp(longint'($signed(mem[aw])) - mulsh(lr, mem[ag]), s2);
        exp_q.push_back({aw, wn});
        exp_sat = exp_sat | s2;
      end
    end
  endtask

  // Drives config plus a one-cycle go; returns at the first cycle after go.
  task automatic start_run(bit md, int len, logic [AW-1:0] wb, logic [AW-1:0] gb,
                           logic [AW-1:0] vb, logic [DW-1:0] lr, logic [DW-1:0] mu);
`ifdef PARAM_UPDATE_MOMENTUM_EN
    eff_mom = md;
`else
    eff_mom = 1'b0;
`endif
    @(negedge clk_i);
    mode_i = md; len_i = LW'(len); w_base_i = wb; g_base_i = gb; v_base_i = vb;
    lr_i = lr; mu_i = mu; go_i = 1'b1;
    push_expect(eff_mom, len, wb, gb, vb, lr, mu);
    @(negedge clk_i);
    go_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done_o !== 1'b1 && lat < 400) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  function automatic int exp_lat(int len);
    return (eff_mom ? 9 : 6) * len + 1;
  endfunction

  task automatic check_end(string name, int lat, int want_lat);
    checks++;
    if (lat !== want_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, want_lat);
    end
    checks++;
    if (sat_o !== exp_sat) begin
      errors++;
      $display("FAIL %s_sat: got %b, required %b", name, sat_o, exp_sat);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy_o, done_o, sat_o, mem_req_o, mem_we_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {busy_o, done_o, sat_o, mem_req_o, mem_we_o});
    end
    checks++;
    if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", mem_addr_o, mem_wdata_o);
    end
  endtask

  task automatic test_sgd_basic;
    int lat;
    mem[16'h0100] = 32'h0005_0000;
    mem[16'h0200] = 32'h0002_0000;
    start_run(1'b0, 1, 16'h0100, 16'h0200, 16'h0300, 32'h0000_8000, 32'h0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL sgd_busy: got %b, required 1", busy_o);
    end
    wait_done(lat);
    check_end("sgd", lat, 7);
    checks++;
    if (mem[16'h0100] !== 32'h0004_0000) begin
      errors++;
      $display("FAIL sgd_value: got %h, required 00040000", mem[16'h0100]);
    end
  endtask

  task automatic test_momentum;
    int lat;
    logic [DW-1:0] want_w;
    mem[16'h0110] = 32'h0003_0000;
    mem[16'h0210] = 32'h0001_0000;
    mem[16'h0310] = 32'h0002_0000;
    start_run(1'b1, 1, 16'h0110, 16'h0210, 16'h0310, 32'h0000_8000, 32'h0000_8000);
`ifdef PARAM_UPDATE_MOMENTUM_EN
    want_w = 32'h0002_0000;
`else
    want_w = 32'h0002_8000;
`endif
    wait_done(lat);
    check_end("mom", lat, exp_lat(1));
    checks++;
    if (mem[16'h0110] !== want_w) begin
      errors++;
      $display("FAIL mom_value: got %h, required %h", mem[16'h0110], want_w);
    end
  endtask

  task automatic test_floor;
    int lat;
    mem[16'h0120] = 32'h0;
    mem[16'h0220] = 32'hFFFF_FFFF;
    start_run(1'b0, 1, 16'h0120, 16'h0220, 16'h0320, 32'h0000_8000, 32'h0);
    wait_done(lat);
    check_end("floor", lat, 7);
    checks++;
    if (mem[16'h0120] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL floor_value: got %h, required 00000001", mem[16'h0120]);
    end
  endtask

  task automatic test_saturation;
    int lat;
    mem[16'h0130] = 32'h8000_0001; mem[16'h0230] = 32'h0001_0000;
    mem[16'h0131] = 32'h0001_0000; mem[16'h0231] = 32'h0001_0000;
    mem[16'h0132] = 32'h0005_0000; mem[16'h0232] = 32'h0001_0000;
    start_run(1'b0, 3, 16'h0130, 16'h0230, 16'h0330, 32'h0001_0000, 32'h0);
    wait_done(lat);
    check_end("sat", lat, 19);
    checks++;
    if (mem[16'h0130] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sat_value: got %h, required 80000000", mem[16'h0130]);
    end
    @(negedge clk_i);
    checks++;
    if (sat_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky_idle: got %b, required 1", sat_o);
    end
    mem[16'h0140] = 32'h0001_0000; mem[16'h0240] = 32'h0;
    start_run(1'b0, 1, 16'h0140, 16'h0240, 16'h0340, 32'h0001_0000, 32'h0);
    checks++;
    if (sat_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_cleared: got %b, required 0", sat_o);
    end
    wait_done(lat);
    check_end("sat_clear", lat, 7);
  endtask

  task automatic test_len_zero;
    int lat, req0;
    req0 = req_cycles;
    start_run(1'b0, 0, 16'h0150, 16'h0250, 16'h0350, 32'h0001_0000, 32'h0);
    wait_done(lat);
    check_end("len0", lat, 1);
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL len0_pulse: got done/busy=%b, required 00", {done_o, busy_o});
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (req_cycles != req0) begin
      errors++;
      $display("FAIL len0_noreq: got %0d request cycles, required 0", req_cycles - req0);
    end
  endtask

  task automatic test_wrap;
    int lat;
    mem[16'hFFFF] = 32'h0004_0000; mem[16'h0400] = 32'h0001_0000;
    mem[16'h0000] = 32'h0002_0000; mem[16'h0401] = 32'h0002_0000;
    start_run(1'b0, 2, 16'hFFFF, 16'h0400, 16'h0500, 32'h0000_8000, 32'h0);
    wait_done(lat);
    check_end("wrap", lat, 13);
    checks++;
    if (mem[16'h0000] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL wrap_value: got %h, required 00010000", mem[16'h0000]);
    end
  endtask

  task automatic test_stall;
    int lat;
    mem[16'h0160] = 32'h0005_0000; mem[16'h0260] = 32'h0002_0000;
    stall_req = 3;
    start_run(1'b0, 1, 16'h0160, 16'h0260, 16'h0360, 32'h0000_8000, 32'h0);
    wait_done(lat);
    check_end("stall", lat, 10);
  endtask

  task automatic test_go_busy;
    int lat;
    mem[16'h0170] = 32'h0003_0000; mem[16'h0270] = 32'h0002_0000;
    mem[16'h0171] = 32'h0001_0000; mem[16'h0271] = 32'hFFFE_0000;
    start_run(1'b0, 2, 16'h0170, 16'h0270, 16'h0370, 32'h0000_8000, 32'h0);
    lat = 1;
    while (done_o !== 1'b1 && lat < 400) begin
      if (lat == 3) begin
        go_i = 1'b1; len_i = 16'd5; lr_i = 32'h0001_0000; w_base_i = 16'h0600; mode_i = 1'b1;
      end else begin
        go_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    go_i = 1'b0;
    check_end("gobusy", lat, 13);
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL gobusy_idle: got busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0180 + 16'(i)] = 32'h0001_0000;
      mem[16'h0280 + 16'(i)] = 32'h0001_0000;
      mem[16'h0380 + 16'(i)] = 32'h0001_0000;
    end
    start_run(1'b1, 4, 16'h0180, 16'h0280, 16'h0380, 32'h0001_0000, 32'h0001_0000);
    repeat (8) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    test_reset;
    rst_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
  endtask

  task automatic test_random;
    int lat, len;
    bit md;
    logic [AW-1:0] wb, gb, vb;
    for (int k = 0; k < 4; k++) begin
      len = int'($urandom_range(1, 3));
      md  = 1'($urandom_range(0, 1));
      wb  = 16'h1000 + 16'(k * 16);
      gb  = 16'h2000 + 16'(k * 16);
      vb  = 16'h3000 + 16'(k * 16);
      for (int i = 0; i < len; i++) begin
        mem[wb + 16'(i)] = (k == 3) ? 32'h7FFF_0000 : $urandom;
        mem[gb + 16'(i)] = (k == 3) ? 32'h8000_0000 : $urandom;
        mem[vb + 16'(i)] = $urandom;
      end
      start_run(md, len, wb, gb, vb, $urandom_range(0, 32'h0002_0000),
                $urandom_range(0, 32'h0001_0000));
      wait_done(lat);
      check_end("random", lat, exp_lat(len));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; go_i = 1'b0; mode_i = 1'b0; len_i = '0;
    w_base_i = '0; g_base_i = '0; v_base_i = '0; lr_i = '0; mu_i = '0;
    repeat (3) @(negedge clk_i);
    test_reset;
    rst_i = 1'b0;
    @(negedge clk_i);
    test_reset;
    test_sgd_basic;
    test_momentum;
    test_floor;
    test_saturation;
    test_len_zero;
    test_wrap;
    test_stall;
    test_go_busy;
    test_reset_mid;
    test_random;
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
